// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use / RAW stall detection,
// branch flush sequencing and saturating event counters.
module pipe_hazard_unit #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int FWD_EN    = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic [REG_AW-1:0] edestReg,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [REG_AW-1:0] mdestReg,
  input  logic              wwreg,
  input  logic [REG_AW-1:0] wdestReg,
  input  logic              branch_taken,
  input  logic              cnt_clr,
  input  logic [DATA_W-1:0] er,
  input  logic [DATA_W-1:0] mr,
  input  logic [DATA_W-1:0] mdo,
  input  logic [DATA_W-1:0] wbData,
  input  logic [DATA_W-1:0] qa,
  input  logic [DATA_W-1:0] qb,
  output logic [DATA_W-1:0] fwd_a,
  output logic [DATA_W-1:0] fwd_b,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // The branch cycle is flush cycle 1, so the FLUSH state holds FLUSH_CYC-1 more.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYC - 1);

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_EX  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_WB  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]  state_q;
  logic [1:0]  state_nxt;
  logic [1:0]  fcnt_q;
  logic [1:0]  fcnt_nxt;

  logic        ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
  logic        hazard;
  logic        flush_st;
  logic        fwd_hit;
  logic [1:0]  sel_a, sel_b;

  function automatic logic src_match(input logic              used,
                                     input logic              wr,
                                     input logic [REG_AW-1:0] dest,
                                     input logic [REG_AW-1:0] src);
    return used && wr && (dest == src) && (src != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m, input logic wb_m,
                                         input logic ex_load);
    if (ex_m && !ex_load) return SEL_EX;
    else if (mem_m)       return SEL_MEM;
    else if (wb_m)        return SEL_WB;
    else                  return SEL_REG;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    if (inc && (cnt != CNT_MAX)) return cnt + 1'b1;
    else                         return cnt;
  endfunction

  assign ex_rs  = src_match(use_rs, ewreg, edestReg, rs);
  assign ex_rt  = src_match(use_rt, ewreg, edestReg, rt);
  assign mem_rs = src_match(use_rs, mwreg, mdestReg, rs);
  assign mem_rt = src_match(use_rt, mwreg, mdestReg, rt);
  assign wb_rs  = src_match(use_rs, wwreg, wdestReg, rs);
  assign wb_rt  = src_match(use_rt, wwreg, wdestReg, rt);

  always_comb begin
    sel_a  = SEL_REG;
    sel_b  = SEL_REG;
    hazard = 1'b0;
    if (FWD_EN != 0) begin
      sel_a  = fwd_sel(ex_rs, mem_rs, wb_rs, em2reg);
      sel_b  = fwd_sel(ex_rt, mem_rt, wb_rt, em2reg);
      hazard = (ex_rs || ex_rt) && em2reg;
    end else begin
      hazard = ex_rs || ex_rt || mem_rs || mem_rt;
    end
  end

  always_comb begin
    fwd_a = qa;
    case (sel_a)
      SEL_EX:  fwd_a = er;
      SEL_MEM: fwd_a = mm2reg ? mdo : mr;
      SEL_WB:  fwd_a = wbData;
      default: fwd_a = qa;
    endcase
  end

  always_comb begin
    fwd_b = qb;
    case (sel_b)
      SEL_EX:  fwd_b = er;
      SEL_MEM: fwd_b = mm2reg ? mdo : mr;
      SEL_WB:  fwd_b = wbData;
      default: fwd_b = qb;
    endcase
  end

  assign fwd_hit = (sel_a != SEL_REG) || (sel_b != SEL_REG);

  // Reset forces state/fcnt to zero, which also drops the state-based flush term.
  assign flush_st = (state_q == ST_FLUSH) && (fcnt_q != 2'd0);
  assign flush    = branch_taken || flush_st;
  assign stall    = hazard && !flush;
  assign bubble   = hazard && !flush;
  assign state    = state_q;

  always_comb begin
    state_nxt = state_q;
    fcnt_nxt  = fcnt_q;
    if (branch_taken) begin
      state_nxt = ST_FLUSH;
      fcnt_nxt  = FLUSH_LOAD;
    end else begin
      case (state_q)
        ST_RUN:   if (hazard) state_nxt = ST_STALL;
        ST_STALL: if (!hazard) state_nxt = ST_RUN;
        ST_FLUSH: begin
          if (fcnt_q == 2'd0) state_nxt = ST_RUN;
          else                fcnt_nxt  = fcnt_q - 2'd1;
        end
        default:  state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_nxt;
      fcnt_q  <= fcnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, stall);
      flush_cnt <= sat_inc(flush_cnt, branch_taken);
      fwd_cnt   <= sat_inc(fwd_cnt, fwd_hit);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: a forwarding instance (FLUSH_CYC=2, CNT_W=4)
// and a stall-only instance share stimulus; a negedge monitor drains the expected queue.
module tb_pipe_hazard_unit;
  localparam int DW = 32;
  localparam int AW = 5;

  localparam int I_STALL_A = 0;
  localparam int I_BUB_A   = 1;
  localparam int I_FLUSH_A = 2;
  localparam int I_STATE_A = 3;
  localparam int I_FWDA_A  = 4;
  localparam int I_FWDB_A  = 5;
  localparam int I_SCNT_A  = 6;
  localparam int I_FCNT_A  = 7;
  localparam int I_WCNT_A  = 8;
  localparam int I_STALL_B = 9;
  localparam int I_FWDA_B  = 10;
  localparam int I_SCNT_B  = 11;
  localparam int I_STATE_B = 12;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] rs, rt, edestReg, mdestReg, wdestReg;
  logic use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg, wwreg, branch_taken, cnt_clr;
  logic [DW-1:0] er, mr, mdo, wbData, qa, qb;

  logic [DW-1:0] fwd_a_a, fwd_b_a, fwd_a_b, fwd_b_b;
  logic stall_a, bubble_a, flush_a, stall_b, bubble_b, flush_b;
  logic [1:0] state_a, state_b;
  logic [3:0] scnt_a, fcnt_a, wcnt_a;
  logic [15:0] scnt_b, fcnt_b, wcnt_b;

  pipe_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .FWD_EN(1), .FLUSH_CYC(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .ewreg(ewreg), .em2reg(em2reg), .edestReg(edestReg), .mwreg(mwreg), .mm2reg(mm2reg),
    .mdestReg(mdestReg), .wwreg(wwreg), .wdestReg(wdestReg), .branch_taken(branch_taken),
    .cnt_clr(cnt_clr), .er(er), .mr(mr), .mdo(mdo), .wbData(wbData), .qa(qa), .qb(qb),
    .fwd_a(fwd_a_a), .fwd_b(fwd_b_a), .stall(stall_a), .bubble(bubble_a), .flush(flush_a),
    .state(state_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a), .fwd_cnt(wcnt_a));

  pipe_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .FWD_EN(0), .FLUSH_CYC(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .ewreg(ewreg), .em2reg(em2reg), .edestReg(edestReg), .mwreg(mwreg), .mm2reg(mm2reg),
    .mdestReg(mdestReg), .wwreg(wwreg), .wdestReg(wdestReg), .branch_taken(branch_taken),
    .cnt_clr(cnt_clr), .er(er), .mr(mr), .mdo(mdo), .wbData(wbData), .qa(qa), .qb(qb),
    .fwd_a(fwd_a_b), .fwd_b(fwd_b_b), .stall(stall_b), .bubble(bubble_b), .flush(flush_b),
    .state(state_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b), .fwd_cnt(wcnt_b));

  // Clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  logic [DW-1:0] exp_q[$];
  int id_q[$];
  int cyc_q[$];
  int total = 0;
  int bad = 0;

  task automatic exp_v(input int id, input logic [DW-1:0] v);
    exp_q.push_back(v);
    id_q.push_back(id);
    cyc_q.push_back(cyc);
  endtask

  function automatic logic [DW-1:0] actual(input int id);
    case (id)
      I_STALL_A: return {31'd0, stall_a};
      I_BUB_A:   return {31'd0, bubble_a};
      I_FLUSH_A: return {31'd0, flush_a};
      I_STATE_A: return {30'd0, state_a};
      I_FWDA_A:  return fwd_a_a;
      I_FWDB_A:  return fwd_b_a;
      I_SCNT_A:  return {28'd0, scnt_a};
      I_FCNT_A:  return {28'd0, fcnt_a};
      I_WCNT_A:  return {28'd0, wcnt_a};
      I_STALL_B: return {31'd0, stall_b};
      I_FWDA_B:  return fwd_a_b;
      I_SCNT_B:  return {16'd0, scnt_b};
      I_STATE_B: return {30'd0, state_b};
      default:   return 'x;
    endcase
  endfunction

  function automatic string sig_name(input int id);
    case (id)
      I_STALL_A: return "stall_a";
      I_BUB_A:   return "bubble_a";
      I_FLUSH_A: return "flush_a";
      I_STATE_A: return "state_a";
      I_FWDA_A:  return "fwd_a_a";
      I_FWDB_A:  return "fwd_b_a";
      I_SCNT_A:  return "stall_cnt_a";
      I_FCNT_A:  return "flush_cnt_a";
      I_WCNT_A:  return "fwd_cnt_a";
      I_STALL_B: return "stall_b";
      I_FWDA_B:  return "fwd_a_b";
      I_SCNT_B:  return "stall_cnt_b";
      I_STATE_B: return "state_b";
      default:   return "unknown";
    endcase
  endfunction

  // Monitor: outputs are settled mid-cycle; drain everything issued for this cycle.
  always @(negedge clk) begin
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      logic [DW-1:0] e, a;
      int id, c;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      c  = cyc_q.pop_front();
      a  = actual(id);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h", sig_name(id), c, a, e);
      end
    end
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
    rs = '0; rt = '0; use_rs = 1'b0; use_rt = 1'b0;
    ewreg = 1'b0; em2reg = 1'b0; edestReg = '0;
    mwreg = 1'b0; mm2reg = 1'b0; mdestReg = '0;
    wwreg = 1'b0; wdestReg = '0;
    branch_taken = 1'b0; cnt_clr = 1'b0;
    er = 32'h11; mr = 32'h22; mdo = 32'hDEAD; wbData = 32'h33;
    qa = 32'hAAAA_0000; qb = 32'hBBBB_0000;
  endtask

  task automatic load_use_r3();
    ewreg = 1'b1; em2reg = 1'b1; edestReg = 5'd3;
    rs = 5'd3; use_rs = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;

    // Reset state
    next_cycle();
    exp_v(I_STATE_A, 0); exp_v(I_SCNT_A, 0); exp_v(I_FCNT_A, 0); exp_v(I_WCNT_A, 0);
    exp_v(I_FLUSH_A, 0); exp_v(I_STALL_A, 0); exp_v(I_STATE_B, 0);
    next_cycle();
    rst_n = 1'b1;

    // Load-use: stall, then forward MEM load data
    next_cycle();
    load_use_r3();
    exp_v(I_STALL_A, 1); exp_v(I_BUB_A, 1); exp_v(I_FLUSH_A, 0); exp_v(I_STATE_A, 0);
    exp_v(I_STALL_B, 1);
    next_cycle();
    rs = 5'd3; use_rs = 1'b1;
    mwreg = 1'b1; mm2reg = 1'b1; mdestReg = 5'd3; mdo = 32'hDEAD;
    exp_v(I_STATE_A, 1); exp_v(I_STALL_A, 0); exp_v(I_FWDA_A, 32'hDEAD);
    exp_v(I_SCNT_A, 1); exp_v(I_WCNT_A, 0);
    exp_v(I_STALL_B, 1); exp_v(I_FWDA_B, 32'hAAAA_0000);
    next_cycle();
    exp_v(I_STATE_A, 0); exp_v(I_WCNT_A, 1); exp_v(I_SCNT_A, 1);

    // Forward priority EX > MEM > WB, r0 never forwarded
    next_cycle();
    ewreg = 1'b1; edestReg = 5'd5; mwreg = 1'b1; mdestReg = 5'd5; wwreg = 1'b1; wdestReg = 5'd5;
    rs = 5'd5; use_rs = 1'b1; rt = 5'd5; use_rt = 1'b1;
    exp_v(I_FWDA_A, 32'h11); exp_v(I_FWDB_A, 32'h11); exp_v(I_STALL_A, 0);
    exp_v(I_STALL_B, 1); exp_v(I_FWDA_B, 32'hAAAA_0000);
    next_cycle();
    ewreg = 1'b1; edestReg = 5'd0; mwreg = 1'b1; mdestReg = 5'd0; wwreg = 1'b1; wdestReg = 5'd0;
    use_rs = 1'b1; use_rt = 1'b1;
    exp_v(I_FWDA_A, 32'hAAAA_0000); exp_v(I_FWDB_A, 32'hBBBB_0000); exp_v(I_WCNT_A, 2);
    exp_v(I_STALL_B, 0);
    next_cycle();
    mwreg = 1'b1; mdestReg = 5'd5; wwreg = 1'b1; wdestReg = 5'd5; rs = 5'd5; use_rs = 1'b1;
    exp_v(I_FWDA_A, 32'h22); exp_v(I_WCNT_A, 2);
    next_cycle();
    wwreg = 1'b1; wdestReg = 5'd5; rs = 5'd5; use_rs = 1'b1;
    exp_v(I_FWDA_A, 32'h33); exp_v(I_WCNT_A, 3);
    next_cycle();
    ewreg = 1'b1; edestReg = 5'd5; rs = 5'd5;
    exp_v(I_FWDA_A, 32'hAAAA_0000); exp_v(I_WCNT_A, 4);
    next_cycle();
    cnt_clr = 1'b1;
    exp_v(I_WCNT_A, 4);

    // Branch during stall (FLUSH_CYC=2)
    next_cycle();
    load_use_r3();
    exp_v(I_WCNT_A, 0); exp_v(I_SCNT_A, 0); exp_v(I_STALL_A, 1);
    next_cycle();
    load_use_r3();
    branch_taken = 1'b1;
    exp_v(I_STATE_A, 1); exp_v(I_STALL_A, 0); exp_v(I_BUB_A, 0); exp_v(I_FLUSH_A, 1);
    next_cycle();
    exp_v(I_STATE_A, 2); exp_v(I_FLUSH_A, 1); exp_v(I_STALL_A, 0); exp_v(I_FCNT_A, 1);
    exp_v(I_SCNT_A, 1);
    next_cycle();
    exp_v(I_STATE_A, 2); exp_v(I_FLUSH_A, 0);
    next_cycle();
    cnt_clr = 1'b1;
    exp_v(I_STATE_A, 0); exp_v(I_FCNT_A, 1);

    // Stall-only instance: ALU result r7 in EX then MEM
    next_cycle();
    ewreg = 1'b1; edestReg = 5'd7; rs = 5'd7; use_rs = 1'b1;
    exp_v(I_STALL_B, 1); exp_v(I_FWDA_B, 32'hAAAA_0000); exp_v(I_STATE_B, 0); exp_v(I_SCNT_B, 0);
    exp_v(I_FWDA_A, 32'h11); exp_v(I_STALL_A, 0);
    next_cycle();
    mwreg = 1'b1; mdestReg = 5'd7; rs = 5'd7; use_rs = 1'b1;
    exp_v(I_STALL_B, 1); exp_v(I_FWDA_B, 32'hAAAA_0000); exp_v(I_STATE_B, 1);
    next_cycle();
    rs = 5'd7; use_rs = 1'b1;
    exp_v(I_STALL_B, 0); exp_v(I_STATE_B, 1); exp_v(I_SCNT_B, 2);
    next_cycle();
    exp_v(I_STATE_B, 0); exp_v(I_SCNT_B, 2);

    // Saturation: 20 stall cycles on a 4-bit counter
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      load_use_r3();
      exp_v(I_STALL_A, 1);
      exp_v(I_SCNT_A, (k > 15) ? 32'd15 : 32'(k));
    end
    next_cycle();
    load_use_r3();
    cnt_clr = 1'b1;
    exp_v(I_STALL_A, 1); exp_v(I_SCNT_A, 15);

    // Async reset mid-FLUSH
    next_cycle();
    branch_taken = 1'b1;
    exp_v(I_SCNT_A, 0); exp_v(I_FLUSH_A, 1);
    next_cycle();
    #1 rst_n = 1'b0;
    exp_v(I_STATE_A, 0); exp_v(I_FLUSH_A, 0); exp_v(I_FCNT_A, 0); exp_v(I_SCNT_A, 0);
    exp_v(I_STATE_B, 0);
    next_cycle();
    branch_taken = 1'b1;
    exp_v(I_FLUSH_A, 1); exp_v(I_STATE_A, 0); exp_v(I_FCNT_A, 0);
    next_cycle();
    rst_n = 1'b1;
    exp_v(I_FLUSH_A, 0); exp_v(I_STATE_A, 0);
    next_cycle();
    exp_v(I_FLUSH_A, 0); exp_v(I_STATE_A, 0); exp_v(I_FCNT_A, 0);

    next_cycle();
    next_cycle();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameters SHALL be: DATA_W 32 (operand width); REG_AW 5 (register address width); FWD_EN 1 (1 = forwarding, 0 = stall-only mode); FLUSH_CYC 1 (flush length after taken branch, legal 1..3); CNT_W 16 (event counter width).
REQ-002 There SHALL be one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: async active-low reset.
- rs, rt, in, REG_AW each: ID-stage source registers.
- use_rs, use_rt, in, 1 each: ID instruction reads rs / rt.
- ewreg, em2reg, in, 1 each: EX writes register / EX is a load.
- edestReg, in, REG_AW: EX destination register.
- mwreg, mm2reg, in, 1 each: MEM writes register / MEM is a load.
- mdestReg, in, REG_AW: MEM destination register.
- wwreg, in, 1: WB writes register.
- wdestReg, in, REG_AW: WB destination register.
- branch_taken, in, 1: EX resolved a taken branch.
- cnt_clr, in, 1: synchronous counter clear.
- er, mr, mdo, wbData, qa, qb, in, DATA_W each: EX ALU result, MEM ALU result, MEM load data, WB data, register-file reads A and B.
- fwd_a, fwd_b, out, DATA_W each: resolved operands.
- stall, out, 1: hold PC and IF/ID.
- bubble, out, 1: zero ID/EX controls.
- flush, out, 1: kill IF/ID.
- state, out, 2: RUN=0, STALL=1, FLUSH=2.
- stall_cnt, flush_cnt, fwd_cnt, out, CNT_W each: event counters.

Function
REQ-004 A source SHALL "match" a producer only if the source is used, the producer write flag is 1, dest equals the source, and the source is nonzero; register 0 SHALL never match.
REQ-005 When FWD_EN=1, fwd_a SHALL be combinational with priority: EX match and em2reg=0 -> er; else MEM match -> mdo if mm2reg else mr; else WB match -> wbData; else qa. fwd_b SHALL follow the same rule using rt and qb.
REQ-006 When FWD_EN=0, fwd_a SHALL equal qa and fwd_b SHALL equal qb.
REQ-007 A hazard SHALL exist when FWD_EN=1 and EX matches rs or rt with em2reg=1 (load-use), or when FWD_EN=0 and EX or MEM matches rs or rt.
REQ-008 Outputs stall and bubble SHALL be combinational: both equal hazard AND NOT flush.
REQ-009 The FSM SHALL be registered, with these transitions:
- RUN -> FLUSH on branch_taken.
- RUN -> STALL on hazard.
- STALL -> FLUSH on branch_taken.
- STALL -> RUN when the hazard clears.
- FLUSH SHALL last FLUSH_CYC cycles, counted by an internal down-counter, then go to RUN.
REQ-010 flush SHALL equal branch_taken OR (state==FLUSH with the down-counter nonzero); the branch cycle itself SHALL count as flush cycle 1.
REQ-011 branch_taken in FLUSH SHALL reload the down-counter and remain in FLUSH.
REQ-012 When branch_taken and a hazard occur together, flush SHALL win: stall=0, bubble=0, next state FLUSH.
REQ-013 stall_cnt SHALL increment on each cycle with stall=1.
REQ-014 flush_cnt SHALL increment once per branch_taken cycle.
REQ-015 fwd_cnt SHALL increment once per cycle in which either operand takes a forwarded value, and never by 2.
REQ-016 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-017 cnt_clr SHALL zero all counters on the next edge and take priority over increment.

Reset
REQ-018 rst_n=0 SHALL immediately force: state RUN, flush down-counter 0, all counters 0.
REQ-019 During reset, stall, bubble and flush SHALL still reflect the combinational terms, excluding the state-based flush term.
REQ-020 Reset asserted mid-STALL or mid-FLUSH SHALL abort the sequence, with no residual flush after release.

Verification
REQ-021 Load-use forwarding: FWD_EN=1; EX load r3 (ewreg=1, em2reg=1, edestReg=3); ID rs=3, use_rs=1. Required:
- stall=1, bubble=1, state=STALL next cycle.
- Next cycle, MEM load r3 with mdo=0xDEAD: fwd_a=0xDEAD, stall=0, fwd_cnt +1.
REQ-022 Forward priority: EX r5 er=0x11, MEM r5 mr=0x22, WB r5 wbData=0x33, rs=5 -> fwd_a=0x11. With rs=0 in the same setup -> fwd_a=qa.
REQ-023 Branch during stall: hazard active and branch_taken=1 in the same cycle, FLUSH_CYC=2. Required:
- stall=0 and flush=1 for 2 cycles.
- flush_cnt=1.
- state sequence FLUSH, FLUSH, RUN.
REQ-024 Stall-only mode: FWD_EN=0; ALU op to r7 in EX, rs=7. Required:
- stall=1 for 2 cycles (EX then MEM).
- fwd_a=qa throughout.
- stall_cnt=2.
REQ-025 Counter saturation: CNT_W=4 and 20 consecutive stall cycles -> stall_cnt=15. Then cnt_clr=1 together with a stall -> stall_cnt=0.
REQ-026 Async reset: rst_n pulsed low mid-FLUSH between clock edges. Required: state=0 and counters 0 before the next edge, and flush=0 after release.
